// File: rtl/pipe_stage_chain.sv
// Elastic pipeline-register chain: STAGES stages, each holding a valid bit,
// a payload and a sequence tag. Every stage has its own stall and flush
// control; empty stages do not propagate backpressure, so bubbles are
// squeezed out while the output is blocked.
module pipe_stage_chain #(
    parameter int DW     = 32,
    parameter int STAGES = 4,
    parameter int TAG_W  = 5,
    parameter int CNT_W  = 16
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    input  logic [DW-1:0]                in_data,
    output logic                         in_ready,
    input  logic [STAGES-1:0]            stall_mask,
    input  logic [STAGES-1:0]            flush_mask,
    output logic                         out_valid,
    output logic [DW-1:0]                out_data,
    output logic [TAG_W-1:0]             out_tag,
    input  logic                         out_ready,
    output logic [STAGES-1:0]            stage_valid,
    output logic [$clog2(STAGES+1)-1:0]  occupancy,
    output logic [CNT_W-1:0]             drop_count
);

    localparam int OCC_W = $clog2(STAGES + 1);
    // Sum wide enough for counter plus one cycle's worth of drops, with carry.
    localparam int SUM_W = ((CNT_W > OCC_W) ? CNT_W : OCC_W) + 1;
    localparam logic [SUM_W-1:0] DROP_MAX = (SUM_W'(1) << CNT_W) - SUM_W'(1);

    logic [STAGES-1:0] valid_q;
    logic [DW-1:0]     data_q [STAGES];
    logic [TAG_W-1:0]  tag_q  [STAGES];
    logic [TAG_W-1:0]  next_tag_q;
    logic [CNT_W-1:0]  drop_q;

    logic [STAGES-1:0] hold;
    logic [STAGES-1:0] load_valid;
    logic [STAGES-1:0] valid_d;
    logic [OCC_W-1:0]  drop_n;
    logic [SUM_W-1:0]  drop_sum;
    logic              accept;

    // Backpressure chain: a stage holds if stalled, or if it is occupied and
    // the stage ahead of it holds. Empty stages break the chain.
    always_comb begin
        // NOTE: every variable written here gets a default first, so no path
        // through the block can leave it unassigned and infer a latch.
        hold = '0;
        hold[STAGES-1] = stall_mask[STAGES-1] | (valid_q[STAGES-1] & ~out_ready);
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i] = stall_mask[i] | (hold[i+1] & valid_q[i]);
        end
    end

    assign in_ready = ~hold[0];
    assign accept   = in_valid & ~hold[0];

    // Per-stage incoming valid, next valid bit and number of flushed entries.
    always_comb begin
        load_valid = '0;
        valid_d    = '0;
        drop_n     = '0;
        load_valid[0] = in_valid;
        for (int i = 1; i < STAGES; i++) begin
            load_valid[i] = valid_q[i-1] & ~hold[i-1];
        end
        for (int i = 0; i < STAGES; i++) begin
            if (flush_mask[i]) begin
                // Flush beats stall: a held entry or an arriving entry is killed.
                valid_d[i] = 1'b0;
                if (hold[i] ? valid_q[i] : load_valid[i]) begin
                    drop_n = drop_n + OCC_W'(1);
                end
            end else if (hold[i]) begin
                valid_d[i] = valid_q[i];
            end else begin
                valid_d[i] = load_valid[i];
            end
        end
    end

    assign drop_sum = SUM_W'(drop_q) + SUM_W'(drop_n);

    // Stage registers, tag counter and saturating drop counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q    <= '0;
            next_tag_q <= '0;
            drop_q     <= '0;
            // NOTE: the payload and tag arrays are cleared as well because
            // out_data/out_tag must read zero straight after reset.
            for (int i = 0; i < STAGES; i++) begin
                data_q[i] <= '0;
                tag_q[i]  <= '0;
            end
        end else begin
            // NOTE: non-blocking assignments let each stage capture its
            // neighbour's pre-edge contents, so the whole chain shifts at once.
            valid_q <= valid_d;
            drop_q  <= (drop_sum > DROP_MAX) ? DROP_MAX[CNT_W-1:0] : drop_sum[CNT_W-1:0];
            if (accept) begin
                next_tag_q <= next_tag_q + TAG_W'(1);
                data_q[0]  <= in_data;
                tag_q[0]   <= next_tag_q;
            end
            // Payload moves only with a valid entry; bubbles leave it untouched.
            for (int i = 1; i < STAGES; i++) begin
                if (load_valid[i] && !hold[i]) begin
                    data_q[i] <= data_q[i-1];
                    tag_q[i]  <= tag_q[i-1];
                end
            end
        end
    end

    // Occupancy is the population count of the registered valid bits.
    always_comb begin
        occupancy = '0;
        for (int i = 0; i < STAGES; i++) begin
            occupancy = occupancy + OCC_W'(valid_q[i]);
        end
    end

    assign stage_valid = valid_q;
    assign out_valid   = valid_q[STAGES-1];
    assign out_data    = data_q[STAGES-1];
    assign out_tag     = tag_q[STAGES-1];
    assign drop_count  = drop_q;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain: a default instance (TAG_W=5, CNT_W=16)
// and a narrow one (TAG_W=2, CNT_W=2) share one stimulus stream.
module tb_pipe_stage_chain;

    localparam int DW     = 32;
    localparam int STAGES = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset;
    logic              in_valid;
    logic [DW-1:0]     in_data;
    logic [STAGES-1:0] stall_mask;
    logic [STAGES-1:0] flush_mask;
    logic              out_ready;

    logic              in_ready_a, out_valid_a;
    logic [DW-1:0]     out_data_a;
    logic [4:0]        out_tag_a;
    logic [STAGES-1:0] stage_valid_a;
    logic [2:0]        occupancy_a;
    logic [15:0]       drop_count_a;

    logic              in_ready_b, out_valid_b;
    logic [DW-1:0]     out_data_b;
    logic [1:0]        out_tag_b;
    logic [STAGES-1:0] stage_valid_b;
    logic [2:0]        occupancy_b;
    logic [1:0]        drop_count_b;

    pipe_stage_chain #(.DW(DW), .STAGES(STAGES), .TAG_W(5), .CNT_W(16)) dut_a (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_a), .stall_mask(stall_mask), .flush_mask(flush_mask),
        .out_valid(out_valid_a), .out_data(out_data_a), .out_tag(out_tag_a),
        .out_ready(out_ready), .stage_valid(stage_valid_a),
        .occupancy(occupancy_a), .drop_count(drop_count_a)
    );

    pipe_stage_chain #(.DW(DW), .STAGES(STAGES), .TAG_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready_b), .stall_mask(stall_mask), .flush_mask(flush_mask),
        .out_valid(out_valid_b), .out_data(out_data_b), .out_tag(out_tag_b),
        .out_ready(out_ready), .stage_valid(stage_valid_b),
        .occupancy(occupancy_b), .drop_count(drop_count_b)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    bit last_accept;
    int rx_data[$];
    int rx_tag[$];
    int rx_tag_b[$];
    int rx_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int q_at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    // Samples the cycle's handshakes mid-cycle, then advances one clock edge.
    task automatic tick();
        #1;
        if (!reset && out_valid_a && out_ready && !stall_mask[STAGES-1]) begin
            rx_data.push_back(int'(out_data_a));
            rx_tag.push_back(int'(out_tag_a));
            rx_tag_b.push_back(int'(out_tag_b));
            rx_cyc.push_back(cyc);
        end
        last_accept = !reset && in_valid && in_ready_a;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0;
        stall_mask = '0; flush_mask = '0; out_ready = 1'b0;
        tick();
        reset = 1'b0;
        rx_data.delete(); rx_tag.delete(); rx_tag_b.delete(); rx_cyc.delete();
    endtask

    int c0;
    int idx;
    int bp_in[6] = '{1, 2, 0, 0, 3, 4};

    initial begin
        // ---------------- reset state and empty-stage stalls ----------------
        do_reset();
        check("rst_out_valid", out_valid_a, 0);
        check("rst_out_data", out_data_a, 0);
        check("rst_out_tag", out_tag_a, 0);
        check("rst_stage_valid", stage_valid_a, 0);
        check("rst_occupancy", occupancy_a, 0);
        check("rst_drop_count", drop_count_a, 0);

        stall_mask = 4'b0001; in_valid = 1'b1; in_data = 99; #1;
        check("stall_empty_s0_in_ready", in_ready_a, 0);
        tick();
        check("stall_empty_s0_no_load", stage_valid_a, 0);
        stall_mask = 4'b0010; #1;
        check("stall_s1_s0_empty_in_ready", in_ready_a, 1);
        stall_mask = '0; in_valid = 1'b0;

        // ---------------- streaming ----------------
        out_ready = 1'b1;
        c0 = cyc;
        for (int k = 0; k < 13; k++) begin
            in_valid = (k < 8);
            in_data  = k + 1;
            if (k == 4 || k == 7) begin
                #1;
                check("stream_occupancy", occupancy_a, 4);
                check("stream_in_ready", in_ready_a, 1);
            end
            tick();
        end
        check("stream_count", rx_data.size(), 8);
        for (int i = 0; i < 8; i++) begin
            check("stream_data", q_at(rx_data, i), i + 1);
            check("stream_tag", q_at(rx_tag, i), i);
            check("stream_cycle", q_at(rx_cyc, i), c0 + 4 + i);
        end

        // ---------------- backpressure squeeze ----------------
        do_reset();
        for (int k = 0; k < 6; k++) begin
            in_valid = (bp_in[k] != 0);
            in_data  = bp_in[k];
            tick();
        end
        in_valid = 1'b1; in_data = 5; #1;
        check("bp_in_ready", in_ready_a, 0);
        check("bp_stage_valid", stage_valid_a, 4'b1111);
        check("bp_occupancy", occupancy_a, 4);
        check("bp_out_data_held", out_data_a, 1);
        tick();
        in_valid = 1'b0; out_ready = 1'b1; stall_mask = 4'b1000;
        tick();
        tick();
        check("stall3_no_transfer", rx_data.size(), 0);
        check("stall3_data_stable", out_data_a, 1);
        stall_mask = '0;
        for (int k = 0; k < 6; k++) tick();
        check("bp_count", rx_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            check("bp_data", q_at(rx_data, i), i + 1);
            check("bp_tag", q_at(rx_tag, i), i);
        end

        // ---------------- mid-stage stall ----------------
        do_reset();
        out_ready = 1'b1;
        idx = 0;
        for (int n = 0; n < 18; n++) begin
            stall_mask = (n >= 3 && n <= 5) ? 4'b0010 : 4'b0000;
            in_valid   = (idx < 8);
            in_data    = 21 + idx;
            if (n == 4) begin
                #1;
                check("mid_stall_in_ready", in_ready_a, 0);
            end
            tick();
            if (last_accept) idx++;
            if (n == 4) check("mid_stall_stage_valid", stage_valid_a, 4'b0011);
        end
        check("mid_count", rx_data.size(), 8);
        for (int i = 0; i < 8; i++) check("mid_data", q_at(rx_data, i), 21 + i);
        check("mid_gap", q_at(rx_cyc, 1) - q_at(rx_cyc, 0), 4);
        check("mid_resume", q_at(rx_cyc, 2) - q_at(rx_cyc, 1), 1);

        // ---------------- flush ----------------
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 10 + k;
            tick();
        end
        in_valid = 1'b0; stall_mask = 4'b0011; flush_mask = 4'b0011;
        tick();
        stall_mask = '0; flush_mask = '0;
        check("flush_drop_count", drop_count_a, 2);
        check("flush_stage_valid", stage_valid_a, 4'b1000);
        in_valid = 1'b1; in_data = 14;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 6; k++) tick();
        check("flush_count", rx_data.size(), 3);
        check("flush_data0", q_at(rx_data, 0), 10);
        check("flush_data1", q_at(rx_data, 1), 11);
        check("flush_data2", q_at(rx_data, 2), 14);
        check("flush_tag2", q_at(rx_tag, 2), 4);

        // ---------------- tag wrap and drop saturation ----------------
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 11; k++) begin
            in_valid = (k < 6); in_data = 31 + k;
            tick();
        end
        check("wrap_count", rx_tag_b.size(), 6);
        for (int i = 0; i < 6; i++) check("wrap_tag", q_at(rx_tag_b, i), i % 4);
        out_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            in_valid = 1'b1; in_data = 51 + k;
            tick();
        end
        check("sat_full", stage_valid_b, 4'b1111);
        in_valid = 1'b1; in_data = 55; flush_mask = 4'b1111;
        tick();
        check("sat_drop_a4", drop_count_a, 4);
        check("sat_drop_b4", drop_count_b, 3);
        check("sat_empty", stage_valid_a, 0);
        in_data = 56; flush_mask = 4'b0001;
        tick();
        check("sat_drop_a5", drop_count_a, 5);
        check("sat_drop_b5", drop_count_b, 3);
        check("sat_input_flushed", stage_valid_a, 0);
        flush_mask = '0;

        // ---------------- reset mid-flight ----------------
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_data = 41 + k;
            tick();
        end
        in_valid = 1'b0;
        check("mid_flight_stage_valid", stage_valid_a, 4'b0111);
        check("mid_flight_occupancy", occupancy_a, 3);
        do_reset();
        check("rst2_stage_valid", stage_valid_a, 0);
        check("rst2_out_valid", out_valid_a, 0);
        check("rst2_out_data", out_data_a, 0);
        check("rst2_out_tag", out_tag_a, 0);
        check("rst2_occupancy", occupancy_a, 0);
        check("rst2_drop_a", drop_count_a, 0);
        check("rst2_drop_b", drop_count_b, 0);
        out_ready = 1'b1; in_valid = 1'b1; in_data = 60;
        tick();
        in_valid = 1'b0;
        for (int k = 0; k < 5; k++) tick();
        check("rst2_count", rx_data.size(), 1);
        check("rst2_data", q_at(rx_data, 0), 60);
        check("rst2_tag", q_at(rx_tag, 0), 0);
        check("rst2_tag_b", q_at(rx_tag_b, 0), 0);
        check("rst2_no_drops", drop_count_a, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
